// File: rtl/px_stream_pkg.sv
// Shared types and helpers for the pixel streaming blocks (frame sink and stream source).
package px_stream_pkg;

  localparam int XB_DEF = 10;
  localparam int YB_DEF = 10;
  localparam int PB_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Frame-buffer address is {y, x}; callers truncate to XB+YB bits.
  function automatic logic [63:0] pack_addr(input logic [31:0] y, input logic [31:0] x,
                                            input int xb);
    return ({32'd0, y} << xb) | {32'd0, x};
  endfunction

endpackage

// File: rtl/px_raster_cnt.sv
// Raster x/y position counter with configurable width/height; wraps at the frame end.
module px_raster_cnt #(
  parameter int XB = 10,
  parameter int YB = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          advance,
  input  logic [XB-1:0] cfg_w,
  input  logic [YB-1:0] cfg_h,
  output logic [XB-1:0] x,
  output logic [YB-1:0] y,
  output logic          is_last_x,
  output logic          is_last_y
);

  assign is_last_x = (x == cfg_w);
  assign is_last_y = (y == cfg_h);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (is_last_x) begin
        x <= '0;
        y <= is_last_y ? '0 : y + 1'b1;
      end else begin
        x <= x + 1'b1;
      end
    end
  end

endmodule

// File: rtl/px_frame_sink.sv
// Frame sink: writes a raster pixel stream into a frame buffer and checks last_x/last_y framing.
// Optional running pixel checksum output is enabled with `define PX_SINK_CHECKSUM_EN.
module px_frame_sink
  import px_stream_pkg::*;
#(
  parameter int XB = XB_DEF,
  parameter int YB = YB_DEF,
  parameter int PB = PB_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XB-1:0]    cfg_width,
  input  logic [YB-1:0]    cfg_height,
  input  logic             start,
  output logic             px_in_ready,
  input  logic             px_in_valid,
  input  logic             px_in_last_y,
  input  logic             px_in_last_x,
  input  logic [PB-1:0]    px_in_data,
  output logic             mem_wr_en,
  input  logic             mem_wr_ready,
  output logic [XB+YB-1:0] mem_wr_addr,
  output logic [PB-1:0]    mem_wr_data,
  output logic             done,
  output logic             err_framing,
  output logic [XB-1:0]    err_x,
`ifdef PX_SINK_CHECKSUM_EN
  output logic [PB+XB+YB-1:0] checksum,
`endif
  output logic [YB-1:0]    err_y
);

  state_t        state, state_nxt;
  logic [XB-1:0] cfg_w, x;
  logic [YB-1:0] cfg_h, y;
  logic          is_last_x, is_last_y;
  logic          accept, arm, mismatch;

  assign arm         = start && (state == IDLE || state == DONE);
  assign px_in_ready = (state == RUN) && (!mem_wr_en || mem_wr_ready);
  assign accept      = px_in_valid && px_in_ready;
  assign done        = (state == DONE);
  assign mismatch    = (px_in_last_x != is_last_x) || (px_in_last_y != is_last_y);

  px_raster_cnt #(.XB(XB), .YB(YB)) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (arm),
    .advance   (accept),
    .cfg_w     (cfg_w),
    .cfg_h     (cfg_h),
    .x         (x),
    .y         (y),
    .is_last_x (is_last_x),
    .is_last_y (is_last_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cfg_w <= '0;
      cfg_h <= '0;
    end else begin
      state <= state_nxt;
      if (arm) begin
        cfg_w <= cfg_width;
        cfg_h <= cfg_height;
      end
    end
  end

  // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && is_last_x && is_last_y) state_nxt = DRAIN;
      DRAIN:   if (!mem_wr_en || mem_wr_ready) state_nxt = DONE;
      DONE:    if (start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // One-entry write stage; a new beat may replace the entry in the same cycle it retires.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_en   <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
    end else if (accept) begin
      mem_wr_en   <= 1'b1;
      mem_wr_addr <= (XB+YB)'(pack_addr(32'(y), 32'(x), XB));
      mem_wr_data <= px_in_data;
    end else if (mem_wr_ready) begin
      mem_wr_en   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_framing <= 1'b0;
      err_x       <= '0;
      err_y       <= '0;
    end else if (arm) begin
      err_framing <= 1'b0;
      err_x       <= '0;
      err_y       <= '0;
    end else if (accept && mismatch) begin
      err_framing <= 1'b1;
      if (!err_framing) begin
        err_x <= x;
        err_y <= y;
      end
    end
  end

`ifdef PX_SINK_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      checksum <= '0;
    else if (arm)    checksum <= '0;
    else if (accept) checksum <= checksum + (PB+XB+YB)'(px_in_data);
  end
`endif

endmodule

// File: tb/tb_px_frame_sink.sv
// Randomized bench for px_frame_sink against a beat-index reference model of the frame.
module tb_px_frame_sink;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int PB = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [XB-1:0]    cfg_width = '0;
  logic [YB-1:0]    cfg_height = '0;
  logic             start = 1'b0;
  logic             px_in_ready;
  logic             px_in_valid = 1'b0;
  logic             px_in_last_y = 1'b0;
  logic             px_in_last_x = 1'b0;
  logic [PB-1:0]    px_in_data = '0;
  logic             mem_wr_en;
  logic             mem_wr_ready = 1'b0;
  logic [XB+YB-1:0] mem_wr_addr;
  logic [PB-1:0]    mem_wr_data;
  logic             done;
  logic             err_framing;
  logic [XB-1:0]    err_x;
  logic [YB-1:0]    err_y;
`ifdef PX_SINK_CHECKSUM_EN
  logic [PB+XB+YB-1:0] checksum;
`endif

  int checks = 0;
  int errors = 0;

  px_frame_sink #(.XB(XB), .YB(YB), .PB(PB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .start        (start),
    .px_in_ready  (px_in_ready),
    .px_in_valid  (px_in_valid),
    .px_in_last_y (px_in_last_y),
    .px_in_last_x (px_in_last_x),
    .px_in_data   (px_in_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_ready (mem_wr_ready),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .done         (done),
    .err_framing  (err_framing),
    .err_x        (err_x),
`ifdef PX_SINK_CHECKSUM_EN
    .checksum     (checksum),
`endif
    .err_y        (err_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet(input string pfx);
    check({pfx, "_ready"}, px_in_ready, 1'b0);
    check({pfx, "_wr_en"}, mem_wr_en, 1'b0);
    check({pfx, "_done"}, done, 1'b0);
    check({pfx, "_err"}, err_framing, 1'b0);
  endtask

  // Frame model: beat n sits at x = n % (W+1), y = n / (W+1); bad_idx flips last_x on that beat.
  task automatic run_frame(input int w, input int h, input int bad_idx, input int rdy_pct,
                           input int valid_pct, input bit stall, input int fixed_data,
                           input int abort_at);
    int total, n, phase, writes, exp_ex, exp_ey, stall_left, cyc, nx, ny;
    bit pend, pend_now, exp_err, exp_ready, acc, lx, ly;
    logic [XB+YB-1:0] pend_addr;
    logic [PB-1:0]    pend_data;
    longint sum;
    total = (w + 1) * (h + 1);
    n = 0; phase = 1; writes = 0; exp_ex = 0; exp_ey = 0; stall_left = 0; cyc = 0;
    pend = 0; exp_err = 0; sum = 0; pend_addr = '0; pend_data = '0;

    @(posedge clk); #1;
    cfg_width = XB'(w); cfg_height = YB'(h); start = 1'b1;
    px_in_valid = 1'b0; mem_wr_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    while (phase != 3) begin
      nx = n % (w + 1);
      ny = n / (w + 1);
      px_in_valid = (n < total) && ($urandom_range(99) < valid_pct);
      px_in_data  = (fixed_data >= 0) ? PB'(fixed_data) : PB'($urandom);
      lx = (nx == w);
      ly = (ny == h);
      if (n == bad_idx) lx = !lx;
      px_in_last_x = lx;
      px_in_last_y = ly;
      if (stall_left > 0) begin
        mem_wr_ready = 1'b0;
        stall_left--;
      end else begin
        mem_wr_ready = ($urandom_range(99) < rdy_pct);
      end

      @(negedge clk);
      exp_ready = (phase == 1) && (!pend || mem_wr_ready);
      check("px_in_ready", px_in_ready, exp_ready);
      check("mem_wr_en", mem_wr_en, pend);
      if (pend) begin
        check("mem_wr_addr", mem_wr_addr, pend_addr);
        check("mem_wr_data", mem_wr_data, pend_data);
      end
      check("done_early", done, 1'b0);
      check("err_framing_run", err_framing, exp_err);

      acc = px_in_valid && exp_ready;
      pend_now = pend;
      if (pend_now && mem_wr_ready) begin
        writes++;
        pend = 0;
      end
      if (phase == 2) begin
        if (!pend_now || mem_wr_ready) phase = 3;
      end else if (acc) begin
        pend = 1;
        pend_addr = (XB+YB)'((ny << XB) | nx);
        pend_data = px_in_data;
        sum += longint'(px_in_data);
        if (n == bad_idx && !exp_err) begin
          exp_err = 1; exp_ex = nx; exp_ey = ny;
        end
        n++;
        if (n == total) phase = 2;
        if (stall && n == 3) stall_left = 5;
      end

      @(posedge clk); #1;
      if (abort_at >= 0 && n >= abort_at) return;
      cyc++;
      if (cyc > 3000) begin
        check("frame_timeout", 1'b1, 1'b0);
        return;
      end
    end

    px_in_valid = 1'b0;
    check("done", done, 1'b1);
    check("mem_wr_en_done", mem_wr_en, 1'b0);
    check("writes", 64'(writes), 64'(total));
    check("err_framing", err_framing, exp_err);
    check("err_x", err_x, 64'(exp_ex));
    check("err_y", err_y, 64'(exp_ey));
`ifdef PX_SINK_CHECKSUM_EN
    check("checksum", checksum, sum & ((64'd1 << (PB+XB+YB)) - 1));
    if (fixed_data == 255 && total == 16) check("checksum_4080", checksum, 64'd4080);
`endif
  endtask

  initial begin
    int w, h, bad;
    repeat (3) @(posedge clk);
    #1;
    check_quiet("reset");
    check("reset_addr", mem_wr_addr, 0);
    check("reset_data", mem_wr_data, 0);
    check("reset_err_x", err_x, 0);
    check("reset_err_y", err_y, 0);
    rst_n = 1'b1;

    px_in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("idle");
    end
    px_in_valid = 1'b0;

    run_frame(3, 3, -1, 100, 100, 1'b0, -1, -1);
    run_frame(3, 3, -1, 100, 100, 1'b1, -1, -1);
    run_frame(7, 1, 13, 100, 100, 1'b0, -1, -1);
    run_frame(0, 0, -1, 100, 100, 1'b0, -1, -1);

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("rearm_done", done, 1'b0);
    check("rearm_ready", px_in_ready, 1'b1);
    run_frame(0, 0, -1, 100, 100, 1'b0, -1, -1);

    run_frame(3, 3, -1, 100, 100, 1'b0, 255, -1);

    for (int i = 0; i < 8; i++) begin
      w = $urandom_range(5);
      h = $urandom_range(4);
      bad = $urandom_range(1) ? $urandom_range((w + 1) * (h + 1) - 1) : -1;
      run_frame(w, h, bad, 60, 70, 1'b0, -1, -1);
    end

    run_frame(7, 7, -1, 100, 100, 1'b0, -1, 10);
    rst_n = 1'b0;
    #1;
    check_quiet("midreset");
    check("midreset_addr", mem_wr_addr, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    px_in_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_quiet("post_reset");
    end
    px_in_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/px_frame_sink.md
Name: px_frame_sink

Overview:
- Receiving end of the blur filter's output pixel stream: accepts raster pixels tagged with last_x/last_y over ready/valid and writes each into a frame-buffer write port at address x + y*2^XB.
- Counts its own raster position from cfg_width/cfg_height, checks the incoming last flags against it, and reports completion and framing errors.
- Sits directly after the filter core in the streaming chain and is the hardware counterpart of the bench output checker.

Parameters:
- XB, 10, x coordinate width; max width 2^XB.
- YB, 10, y coordinate width; max height 2^YB.
- PB, 8, pixel data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_width  in  XB  frame width minus 1; sampled on start.
- cfg_height  in  YB  frame height minus 1; sampled on start.
- start  in  1  single-cycle arm pulse.
- px_in_ready  out  1  sink can accept a beat.
- px_in_valid  in  1  beat present.
- px_in_last_y  in  1  beat is on the last row.
- px_in_last_x  in  1  beat is in the last column.
- px_in_data  in  PB  pixel value.
- mem_wr_en  out  1  write request, held until accepted.
- mem_wr_ready  in  1  memory accepts the write this cycle.
- mem_wr_addr  out  XB+YB  {y, x} write address.
- mem_wr_data  out  PB  pixel to write.
- done  out  1  frame fully received and written.
- err_framing  out  1  sticky; some last flag mismatched.
- err_x  out  XB  x of the first mismatch.
- err_y  out  YB  y of the first mismatch.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; counters x=y=0; cfg registers 0.
- States:
  - IDLE: start -> latch cfg_width/cfg_height, clear errors, go RUN.
  - RUN: accept beats. On acceptance of the beat at x==W, y==H, go DRAIN.
  - DRAIN: when mem_wr_en=0, or mem_wr_en && mem_wr_ready, go DONE.
  - DONE: done=1. start -> clear done/errors, latch cfg, go RUN.
- start is ignored in RUN and DRAIN.
- px_in_ready = (state==RUN) && (!mem_wr_en || mem_wr_ready). This is combinational from registered state, so the write stage acts as a one-entry pipeline with pass-through on drain.
- Handshake: a beat is accepted when px_in_valid && px_in_ready. On that clock edge:
  - mem_wr_en <= 1;
  - mem_wr_addr <= {y, x};
  - mem_wr_data <= px_in_data;
  - x/y advance.
- Write stage: if mem_wr_ready && mem_wr_en and there is no new acceptance, mem_wr_en <= 0. Addr/data must not change while mem_wr_en && !mem_wr_ready.
- Latency: one cycle from input acceptance to mem_wr_en asserted. Full throughput of 1 beat/clk when mem_wr_ready is held high.
- Counters:
  - x increments per accepted beat; at x==W, x wraps to 0 and y increments.
  - at x==W, y==H, both wrap to 0.
  - Counter positions alone define frame end; the input flags never terminate the frame.
- Framing check, per accepted beat: expected_last_x = (x==W), expected_last_y = (y==H).
  - Any mismatch sets err_framing.
  - The first mismatch in the frame captures err_x/err_y; later mismatches leave them unchanged.
- W=0 or H=0 is legal (degenerate); the first beat can satisfy both last conditions.
- px_in_valid is ignored outside RUN; no beat is accepted.
- Reset mid-frame: immediate return to IDLE, pending write dropped, mem_wr_en=0.

Optional Feature:
- Macro PX_SINK_CHECKSUM_EN.
- Defined:
  - adds output checksum [PB+XB+YB-1:0], the modular sum of all accepted px_in_data in the current frame;
  - cleared on reset and on start;
  - stable once done=1.
- Undefined: port and adder absent; behaviour otherwise identical.

Decomposition:
- Package px_stream_pkg holds:
  - state enum {IDLE, RUN, DRAIN, DONE};
  - default XB/YB/PB constants;
  - address-packing function {y, x}.
- Sub-module px_raster_cnt: x/y counter with advance input, cfg W/H inputs, and is_last_x/is_last_y outputs. The planned stream source block reuses it.

Test Plan:
- W=3, H=3 (4x4), correct flags, mem_wr_ready=1, valid every cycle:
  - 16 writes at addrs 0..3, 1024..1027, 2048..2051, 3072..3075;
  - done asserts 2 cycles after the last beat;
  - err_framing=0.
- Same frame with mem_wr_ready held low 5 cycles after the 3rd beat:
  - px_in_ready=0 for those 5 cycles;
  - addr 2 / data held stable;
  - no beats lost or duplicated.
- W=7, H=1, last_x wrongly set at x=5, y=1:
  - err_framing=1, err_x=5, err_y=1;
  - frame still ends after 16 beats with done=1.
- rst_n pulsed low after 10 beats of an 8x8 frame:
  - outputs 0 the same cycle;
  - px_in_ready=0 until the next start.
- W=0, H=0: a single beat with last_x=last_y=1 gives one write to addr 0, then done. start in DONE re-arms with done=0 the next cycle.
- PX_SINK_CHECKSUM_EN, 4x4 frame of pixel 255: checksum = 4080 at done.
